multicycle_control_unit: RTL and testbench
==========================================

# multicycle_control_unit

Moore-style main controller for the multicycle MIPS core. It sequences the shared datapath (one memory port, one ALU, one immediate extender) across fetch/decode/execute/memory/writeback cycles. It also selects the extender mode per instruction: sign, zero, upper (LUI) or sign-shifted (branch offset). It sits between the instruction register's opcode field and all datapath mux/enable controls, and waits on a memory ready handshake.

## Interface
Parameters: none.

Ports:
- clk  in  1  core clock, all state changes on rising edge
- reset  in  1  synchronous, active-high; forces RESET_S
- Opcode  in  6  IR[31:26], stable from DECODE until instruction end
- MemReady  in  1  memory completes current access this cycle
- IorD  out  1  0 = PC addresses memory, 1 = ALUOut
- MemRead  out  1  memory read request
- MemWrite  out  1  memory write request
- IRWrite  out  1  load instruction register
- PCWrite  out  1  unconditional PC load
- PCWriteCond  out  1  PC load if branch condition true
- BranchNE  out  1  condition is Zero=0 (bne) instead of Zero=1 (beq)
- PCSource  out  2  00 ALU result, 01 ALUOut, 10 jump target
- ALUSrcA  out  1  0 = PC, 1 = reg A
- ALUSrcB  out  2  00 reg B, 01 constant 4, 10 extended immediate
- ALUOp  out  3  000 add, 001 sub, 010 funct-decoded, 011 and, 100 or, 101 pass B
- ExtendMode  out  2  00 sign, 01 zero, 10 imm<<16, 11 sign<<2
- RegDst  out  1  0 = rt, 1 = rd
- MemtoReg  out  1  0 = ALUOut, 1 = MDR
- RegWrite  out  1  register file write
- InstrDone  out  1  one-cycle pulse in final cycle of each instruction
- IllegalInstr  out  1  high while halted on an unknown opcode

## Operation
Opcodes: R 0x00, j 0x02, beq 0x04, bne 0x05, addi 0x08, andi 0x0C, ori 0x0D, lui 0x0F, lw 0x23, sw 0x2B. Any other opcode is illegal.

Every output not listed for a state is 0.
- RESET_S: all outputs 0 → FETCH.
- FETCH: MemRead, ALUSrcB=01, ALUOp=add. IRWrite and PCWrite are asserted only in the cycle MemReady=1; that cycle → DECODE. Otherwise stay.
- DECODE: ALUSrcB=10, ExtendMode=11, ALUOp=add (branch target into ALUOut). Next state by opcode: R→EXEC_R; lw/sw→MEM_ADDR; beq/bne→BRANCH; j→JUMP; addi/andi/ori/lui→EXEC_I; else→ILLEGAL.
- EXEC_R: ALUSrcA, ALUSrcB=00, ALUOp=010 → WB_R.
- WB_R: RegDst, RegWrite, InstrDone → FETCH.
- EXEC_I: ALUSrcA, ALUSrcB=10. Mode by opcode: addi ExtendMode=00 ALUOp=add; andi 01/and; ori 01/or; lui 10/pass B. → WB_I.
- WB_I: RegWrite, InstrDone → FETCH.
- MEM_ADDR: ALUSrcA, ALUSrcB=10, ExtendMode=00, ALUOp=add → MEM_RD (lw) or MEM_WR (sw).
- MEM_RD: IorD, MemRead; MemReady=1 → MEM_WB, else stay.
- MEM_WB: MemtoReg, RegWrite, InstrDone → FETCH.
- MEM_WR: IorD, MemWrite; MemReady=1 → FETCH with InstrDone, else stay.
- BRANCH: ALUSrcA, ALUSrcB=00, ALUOp=sub, PCSource=01, PCWriteCond, BranchNE=(Opcode==0x05), InstrDone → FETCH.
- JUMP: PCSource=10, PCWrite, InstrDone → FETCH.
- ILLEGAL: IllegalInstr=1. Remain until reset; no memory or register activity.

## Timing
- The state register updates on the clk rising edge. Outputs decode combinationally from state, plus Opcode/MemReady where stated above.
- Reset: any state, any cycle, including mid-wait in FETCH/MEM_RD/MEM_WR. Next edge enters RESET_S. Every output reads 0 in that cycle, and a pending MemRead/MemWrite is dropped.
- Latency with MemReady tied high: beq/bne/j 3 cycles; R, I-type, sw 4; lw 5. Each cycle of MemReady=0 in FETCH, MEM_RD or MEM_WR adds one cycle.
- MemRead/MemWrite remain asserted and address controls remain stable through wait cycles.
- IRWrite/PCWrite never assert in a FETCH cycle with MemReady=0.
- MemReady outside memory states is ignored.
- Exactly one InstrDone pulse per completed instruction; none for an illegal opcode.

## Structure
- Shared package mips_ctrl_pkg holds:
  - opcode constants
  - state enum
  - ALUOp, ExtendMode, ALUSrcB, PCSource encodings (also used by the ALU control and extender blocks)
- Top holds the state register and next-state logic.
- One combinational sub-module, ctrl_output_decode, maps (state, Opcode, MemReady) to the control outputs.

## Test plan
- Reset held 2 cycles, then released with MemReady=1 and Opcode=0x00 → outputs all 0 during reset; FETCH, DECODE, EXEC_R, WB_R; RegDst=1, RegWrite=1 and InstrDone=1 in cycle 4.
- lw (0x23) with MemReady low for 3 cycles in MEM_RD → MemRead and IorD held 4 cycles; MEM_WB follows with MemtoReg=1; total 8 cycles.
- Each of addi/andi/ori/lui → ExtendMode 00/01/01/10 and ALUOp add/and/or/pass B in EXEC_I.
- beq then bne → BRANCH cycle has PCWriteCond=1, PCSource=01, BranchNE 0 then 1. DECODE has ExtendMode=11.
- Opcode 0x3F → ILLEGAL; IllegalInstr stays 1 for 10 cycles with no InstrDone; reset recovers to FETCH.
- Reset asserted during MEM_WR wait → MemWrite=0 next cycle, then FETCH.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// mips_ctrl_pkg : opcodes, controller states and datapath control encodings
// Rev 1.0
// ============================================================================
package mips_ctrl_pkg;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_ANDI = 6'h0C;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_LUI  = 6'h0F;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  localparam logic [2:0] ALUOP_ADD   = 3'b000;
  localparam logic [2:0] ALUOP_SUB   = 3'b001;
  localparam logic [2:0] ALUOP_FUNCT = 3'b010;
  localparam logic [2:0] ALUOP_AND   = 3'b011;
  localparam logic [2:0] ALUOP_OR    = 3'b100;
  localparam logic [2:0] ALUOP_PASSB = 3'b101;

  localparam logic [1:0] EXT_SIGN   = 2'b00;
  localparam logic [1:0] EXT_ZERO   = 2'b01;
  localparam logic [1:0] EXT_UPPER  = 2'b10;
  localparam logic [1:0] EXT_SHIFT2 = 2'b11;

  localparam logic [1:0] SRCB_REGB = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    RESET_S  = 4'd0,
    FETCH    = 4'd1,
    DECODE   = 4'd2,
    EXEC_R   = 4'd3,
    WB_R     = 4'd4,
    EXEC_I   = 4'd5,
    WB_I     = 4'd6,
    MEM_ADDR = 4'd7,
    MEM_RD   = 4'd8,
    MEM_WB   = 4'd9,
    MEM_WR   = 4'd10,
    BRANCH   = 4'd11,
    JUMP     = 4'd12,
    ILLEGAL  = 4'd13
  } state_t;

  typedef struct packed {
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic       branch_ne;
    logic [1:0] pc_source;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] extend_mode;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       instr_done;
    logic       illegal_instr;
  } ctrl_t;

  // First execution state for an instruction once its opcode is decoded.
  function automatic state_t decode_target(input logic [5:0] op);
    case (op)
      OP_R:                            decode_target = EXEC_R;
      OP_LW, OP_SW:                    decode_target = MEM_ADDR;
      OP_BEQ, OP_BNE:                  decode_target = BRANCH;
      OP_J:                            decode_target = JUMP;
      OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: decode_target = EXEC_I;
      default:                         decode_target = ILLEGAL;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/ctrl_output_decode.sv
`default_nettype none
// ============================================================================
// ctrl_output_decode : maps controller state, opcode and MemReady to controls
// Rev 1.0
// ============================================================================
module ctrl_output_decode
  import mips_ctrl_pkg::*;
(
  input  state_t      i_state,
  input  logic [5:0]  i_opcode,
  input  logic        i_mem_ready,
  output ctrl_t       o_ctrl
);

  always_comb begin
    o_ctrl = '0;
    case (i_state)
      FETCH: begin
        o_ctrl.mem_read  = 1'b1;
        o_ctrl.alu_src_b = SRCB_FOUR;
        o_ctrl.alu_op    = ALUOP_ADD;
        o_ctrl.ir_write  = i_mem_ready;
        o_ctrl.pc_write  = i_mem_ready;
      end
      DECODE: begin
        o_ctrl.alu_src_b   = SRCB_IMM;
        o_ctrl.extend_mode = EXT_SHIFT2;
        o_ctrl.alu_op      = ALUOP_ADD;
      end
      EXEC_R: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_REGB;
        o_ctrl.alu_op    = ALUOP_FUNCT;
      end
      WB_R: begin
        o_ctrl.reg_dst    = 1'b1;
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.instr_done = 1'b1;
      end
      EXEC_I: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_IMM;
        case (i_opcode)
          OP_ANDI: begin o_ctrl.extend_mode = EXT_ZERO;  o_ctrl.alu_op = ALUOP_AND;   end
          OP_ORI:  begin o_ctrl.extend_mode = EXT_ZERO;  o_ctrl.alu_op = ALUOP_OR;    end
          OP_LUI:  begin o_ctrl.extend_mode = EXT_UPPER; o_ctrl.alu_op = ALUOP_PASSB; end
          default: begin o_ctrl.extend_mode = EXT_SIGN;  o_ctrl.alu_op = ALUOP_ADD;   end
        endcase
      end
      WB_I: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.instr_done = 1'b1;
      end
      MEM_ADDR: begin
        o_ctrl.alu_src_a   = 1'b1;
        o_ctrl.alu_src_b   = SRCB_IMM;
        o_ctrl.extend_mode = EXT_SIGN;
        o_ctrl.alu_op      = ALUOP_ADD;
      end
      MEM_RD: begin
        o_ctrl.iord     = 1'b1;
        o_ctrl.mem_read = 1'b1;
      end
      MEM_WB: begin
        o_ctrl.mem_to_reg = 1'b1;
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.instr_done = 1'b1;
      end
      MEM_WR: begin
        o_ctrl.iord       = 1'b1;
        o_ctrl.mem_write  = 1'b1;
        o_ctrl.instr_done = i_mem_ready;
      end
      BRANCH: begin
        o_ctrl.alu_src_a     = 1'b1;
        o_ctrl.alu_src_b     = SRCB_REGB;
        o_ctrl.alu_op        = ALUOP_SUB;
        o_ctrl.pc_source     = PCSRC_ALUOUT;
        o_ctrl.pc_write_cond = 1'b1;
        o_ctrl.branch_ne     = (i_opcode == OP_BNE);
        o_ctrl.instr_done    = 1'b1;
      end
      JUMP: begin
        o_ctrl.pc_source  = PCSRC_JUMP;
        o_ctrl.pc_write   = 1'b1;
        o_ctrl.instr_done = 1'b1;
      end
      ILLEGAL: o_ctrl.illegal_instr = 1'b1;
      default: o_ctrl = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/multicycle_control_unit.sv
`default_nettype none
// ============================================================================
// multicycle_control_unit : Moore main controller sequencing the multicycle core
// Rev 1.0
// ============================================================================
module multicycle_control_unit
  import mips_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Opcode,
  input  logic       MemReady,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       BranchNE,
  output logic [1:0] PCSource,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUOp,
  output logic [1:0] ExtendMode,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       InstrDone,
  output logic       IllegalInstr
);

  state_t r_state;
  state_t w_next;
  ctrl_t  w_ctrl;

  always_ff @(posedge clk) begin
    if (reset) r_state <= RESET_S;
    else       r_state <= w_next;
  end

  // Memory states hold until MemReady; ILLEGAL is left only through reset.
  always_comb begin
    w_next = r_state;
    case (r_state)
      RESET_S:  w_next = FETCH;
      FETCH:    w_next = MemReady ? DECODE : FETCH;
      DECODE:   w_next = decode_target(Opcode);
      EXEC_R:   w_next = WB_R;
      WB_R:     w_next = FETCH;
      EXEC_I:   w_next = WB_I;
      WB_I:     w_next = FETCH;
      MEM_ADDR: w_next = (Opcode == OP_LW) ? MEM_RD : MEM_WR;
      MEM_RD:   w_next = MemReady ? MEM_WB : MEM_RD;
      MEM_WB:   w_next = FETCH;
      MEM_WR:   w_next = MemReady ? FETCH : MEM_WR;
      BRANCH:   w_next = FETCH;
      JUMP:     w_next = FETCH;
      ILLEGAL:  w_next = ILLEGAL;
      default:  w_next = RESET_S;
    endcase
  end

  ctrl_output_decode u_output_decode (
    .i_state     (r_state),
    .i_opcode    (Opcode),
    .i_mem_ready (MemReady),
    .o_ctrl      (w_ctrl)
  );

  assign IorD         = w_ctrl.iord;
  assign MemRead      = w_ctrl.mem_read;
  assign MemWrite     = w_ctrl.mem_write;
  assign IRWrite      = w_ctrl.ir_write;
  assign PCWrite      = w_ctrl.pc_write;
  assign PCWriteCond  = w_ctrl.pc_write_cond;
  assign BranchNE     = w_ctrl.branch_ne;
  assign PCSource     = w_ctrl.pc_source;
  assign ALUSrcA      = w_ctrl.alu_src_a;
  assign ALUSrcB      = w_ctrl.alu_src_b;
  assign ALUOp        = w_ctrl.alu_op;
  assign ExtendMode   = w_ctrl.extend_mode;
  assign RegDst       = w_ctrl.reg_dst;
  assign MemtoReg     = w_ctrl.mem_to_reg;
  assign RegWrite     = w_ctrl.reg_write;
  assign InstrDone    = w_ctrl.instr_done;
  assign IllegalInstr = w_ctrl.illegal_instr;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control_unit.sv
`default_nettype none
// Scoreboard bench: instruction-level model pushes per-cycle expected controls,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_multicycle_control_unit;

  typedef struct packed {
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic       branch_ne;
    logic [1:0] pc_source;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] extend_mode;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       instr_done;
    logic       illegal_instr;
  } exp_t;

  typedef struct {
    exp_t  v;
    string nm;
  } sb_item_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] Opcode;
  logic       MemReady;
  logic       IorD, MemRead, MemWrite, IRWrite, PCWrite, PCWriteCond, BranchNE;
  logic [1:0] PCSource;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ALUOp;
  logic [1:0] ExtendMode;
  logic       RegDst, MemtoReg, RegWrite, InstrDone, IllegalInstr;

  multicycle_control_unit dut (
    .clk(clk), .reset(reset), .Opcode(Opcode), .MemReady(MemReady),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .BranchNE(BranchNE),
    .PCSource(PCSource), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .ExtendMode(ExtendMode), .RegDst(RegDst), .MemtoReg(MemtoReg),
    .RegWrite(RegWrite), .InstrDone(InstrDone), .IllegalInstr(IllegalInstr)
  );

  always #5 clk = ~clk;

  exp_t act;
  always_comb begin
    act               = '0;
    act.iord          = IorD;
    act.mem_read      = MemRead;
    act.mem_write     = MemWrite;
    act.ir_write      = IRWrite;
    act.pc_write      = PCWrite;
    act.pc_write_cond = PCWriteCond;
    act.branch_ne     = BranchNE;
    act.pc_source     = PCSource;
    act.alu_src_a     = ALUSrcA;
    act.alu_src_b     = ALUSrcB;
    act.alu_op        = ALUOp;
    act.extend_mode   = ExtendMode;
    act.reg_dst       = RegDst;
    act.mem_to_reg    = MemtoReg;
    act.reg_write     = RegWrite;
    act.instr_done    = InstrDone;
    act.illegal_instr = IllegalInstr;
  end

  sb_item_t sb_q[$];
  int n_checks   = 0;
  int n_fail     = 0;
  int done_seen  = 0;
  int done_exp   = 0;
  logic [5:0] legal_ops [10] = '{6'h00, 6'h02, 6'h04, 6'h05, 6'h08,
                                 6'h0C, 6'h0D, 6'h0F, 6'h23, 6'h2B};

  // Monitor: every cycle with a pending expectation is compared mid-cycle.
  always @(negedge clk) begin
    if (InstrDone === 1'b1) done_seen++;
    if (sb_q.size() > 0) begin
      sb_item_t it;
      it = sb_q.pop_front();
      n_checks++;
      if (act !== it.v) begin
        n_fail++;
        $display("FAIL %s @%0t: actual=%06h required=%06h", it.nm, $time, act, it.v);
      end
    end
  end

  // ---------------- reference control vectors ----------------
  function automatic exp_t v_zero();
    exp_t e = '0;
    return e;
  endfunction
  function automatic exp_t v_fetch(input logic rdy);
    exp_t e = '0;
    e.mem_read = 1'b1; e.alu_src_b = 2'b01; e.alu_op = 3'b000;
    e.ir_write = rdy;  e.pc_write = rdy;
    return e;
  endfunction
  function automatic exp_t v_decode();
    exp_t e = '0;
    e.alu_src_b = 2'b10; e.extend_mode = 2'b11; e.alu_op = 3'b000;
    return e;
  endfunction
  function automatic exp_t v_exec_r();
    exp_t e = '0;
    e.alu_src_a = 1'b1; e.alu_src_b = 2'b00; e.alu_op = 3'b010;
    return e;
  endfunction
  function automatic exp_t v_exec_i(input logic [5:0] op);
    exp_t e = '0;
    e.alu_src_a = 1'b1; e.alu_src_b = 2'b10;
    case (op)
      6'h08: begin e.extend_mode = 2'b00; e.alu_op = 3'b000; end
      6'h0C: begin e.extend_mode = 2'b01; e.alu_op = 3'b011; end
      6'h0D: begin e.extend_mode = 2'b01; e.alu_op = 3'b100; end
      default: begin e.extend_mode = 2'b10; e.alu_op = 3'b101; end
    endcase
    return e;
  endfunction
  function automatic exp_t v_wb(input logic rd, input logic mdr);
    exp_t e = '0;
    e.reg_dst = rd; e.mem_to_reg = mdr; e.reg_write = 1'b1; e.instr_done = 1'b1;
    return e;
  endfunction
  function automatic exp_t v_mem_addr();
    exp_t e = '0;
    e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; e.extend_mode = 2'b00; e.alu_op = 3'b000;
    return e;
  endfunction
  function automatic exp_t v_mem_rd();
    exp_t e = '0;
    e.iord = 1'b1; e.mem_read = 1'b1;
    return e;
  endfunction
  function automatic exp_t v_mem_wr(input logic rdy);
    exp_t e = '0;
    e.iord = 1'b1; e.mem_write = 1'b1; e.instr_done = rdy;
    return e;
  endfunction
  function automatic exp_t v_branch(input logic ne);
    exp_t e = '0;
    e.alu_src_a = 1'b1; e.alu_src_b = 2'b00; e.alu_op = 3'b001; e.pc_source = 2'b01;
    e.pc_write_cond = 1'b1; e.branch_ne = ne; e.instr_done = 1'b1;
    return e;
  endfunction
  function automatic exp_t v_jump();
    exp_t e = '0;
    e.pc_source = 2'b10; e.pc_write = 1'b1; e.instr_done = 1'b1;
    return e;
  endfunction
  function automatic exp_t v_illegal();
    exp_t e = '0;
    e.illegal_instr = 1'b1;
    return e;
  endfunction

  function automatic logic [5:0] rop();
    return 6'($urandom);
  endfunction
  function automatic logic rbit();
    return 1'($urandom);
  endfunction
  function automatic bit is_legal(input logic [5:0] op);
    for (int i = 0; i < 10; i++) if (legal_ops[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  // ---------------- stimulus ----------------
  task automatic step(input logic rst, input logic [5:0] op, input logic rdy,
                      input bit chk, input exp_t e, input string nm);
    sb_item_t it;
    @(posedge clk); #1;
    reset = rst; Opcode = op; MemReady = rdy;
    if (chk) begin
      it.v = e; it.nm = nm;
      sb_q.push_back(it);
    end
  endtask

  task automatic do_reset(input int n, input bit chk_first, input exp_t first);
    step(1'b1, rop(), 1'b0, chk_first, first, "reset_entry");
    for (int i = 1; i < n; i++) step(1'b1, rop(), rbit(), 1'b1, v_zero(), "reset_hold");
    step(1'b0, rop(), rbit(), 1'b1, v_zero(), "reset_release");
  endtask

  task automatic run_instr(input logic [5:0] op, input int fw, input int mw, input bit complete);
    for (int i = 0; i < fw; i++) step(1'b0, rop(), 1'b0, 1'b1, v_fetch(1'b0), "fetch_wait");
    step(1'b0, rop(), 1'b1, 1'b1, v_fetch(1'b1), "fetch");
    step(1'b0, op, rbit(), 1'b1, v_decode(), "decode");
    case (op)
      6'h00: begin
        step(1'b0, op, rbit(), 1'b1, v_exec_r(), "exec_r");
        step(1'b0, op, rbit(), 1'b1, v_wb(1'b1, 1'b0), "wb_r");
        done_exp++;
      end
      6'h08, 6'h0C, 6'h0D, 6'h0F: begin
        step(1'b0, op, rbit(), 1'b1, v_exec_i(op), "exec_i");
        step(1'b0, op, rbit(), 1'b1, v_wb(1'b0, 1'b0), "wb_i");
        done_exp++;
      end
      6'h23: begin
        step(1'b0, op, rbit(), 1'b1, v_mem_addr(), "lw_addr");
        for (int i = 0; i < mw; i++) step(1'b0, op, 1'b0, 1'b1, v_mem_rd(), "mem_rd_wait");
        if (complete) begin
          step(1'b0, op, 1'b1, 1'b1, v_mem_rd(), "mem_rd");
          step(1'b0, op, rbit(), 1'b1, v_wb(1'b0, 1'b1), "mem_wb");
          done_exp++;
        end
      end
      6'h2B: begin
        step(1'b0, op, rbit(), 1'b1, v_mem_addr(), "sw_addr");
        for (int i = 0; i < mw; i++) step(1'b0, op, 1'b0, 1'b1, v_mem_wr(1'b0), "mem_wr_wait");
        if (complete) begin
          step(1'b0, op, 1'b1, 1'b1, v_mem_wr(1'b1), "mem_wr");
          done_exp++;
        end
      end
      6'h04, 6'h05: begin
        step(1'b0, op, rbit(), 1'b1, v_branch(op == 6'h05), "branch");
        done_exp++;
      end
      6'h02: begin
        step(1'b0, op, rbit(), 1'b1, v_jump(), "jump");
        done_exp++;
      end
      default: begin
        for (int i = 0; i < 10; i++) step(1'b0, rop(), rbit(), 1'b1, v_illegal(), "illegal_hold");
      end
    endcase
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] op;
    reset = 1'b1; Opcode = 6'h00; MemReady = 1'b0;
    do_reset(2, 1'b0, v_zero());

    run_instr(6'h00, 0, 0, 1'b1);
    run_instr(6'h23, 0, 3, 1'b1);
    run_instr(6'h08, 0, 0, 1'b1);
    run_instr(6'h0C, 0, 0, 1'b1);
    run_instr(6'h0D, 0, 0, 1'b1);
    run_instr(6'h0F, 0, 0, 1'b1);
    run_instr(6'h04, 0, 0, 1'b1);
    run_instr(6'h05, 0, 0, 1'b1);
    run_instr(6'h2B, 2, 1, 1'b1);
    run_instr(6'h02, 1, 0, 1'b1);

    run_instr(6'h3F, 0, 0, 1'b1);
    do_reset(1, 1'b1, v_illegal());

    run_instr(6'h2B, 0, 2, 1'b0);
    do_reset(1, 1'b1, v_mem_wr(1'b0));

    do op = rop(); while (is_legal(op));
    run_instr(op, 0, 0, 1'b1);
    do_reset(2, 1'b1, v_illegal());

    for (int n = 0; n < 40; n++) begin
      op = legal_ops[$urandom_range(0, 9)];
      run_instr(op, $urandom_range(0, 2), $urandom_range(0, 2), 1'b1);
    end

    @(posedge clk); #1;
    @(negedge clk); #1;
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: actual=%0d pending required=0", sb_q.size());
    end
    n_checks++;
    if (done_seen != done_exp) begin
      n_fail++;
      $display("FAIL instr_done_count: actual=%0d required=%0d", done_seen, done_exp);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
